csr_unit: RTL and testbench

- Machine-mode CSR file for the 3-stage RISC-V core.
- Executes the CSR instructions identified by `control_logic` (`csr_wen`, `csr_sel`): CSRRW/S/C and their immediate forms.
- Holds the `tohost` register and the 64-bit cycle and instret counters.
- Returns the old CSR value, registered, to the writeback stage.

---
 rtl/csr_unit.sv | 146 ++++++++++++++
 tb/tb_csr_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file (tohost, cycle, instret) for the 3-stage core.
// Optional counters are built only when CSR_COUNTERS_EN is defined.
module csr_unit #(
  parameter logic [11:0] TOHOST_ADDR  = 12'h51E,
  parameter logic [31:0] RESET_TOHOST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        csr_wen,
  input  logic        csr_sel,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  uimm,
  input  logic [31:0] rs1_data,
  input  logic        inst_retire,
  output logic [31:0] csr_rdata,
  output logic [31:0] tohost,
  output logic        illegal
);

  logic [31:0] r_rdata;
  logic [31:0] r_tohost;
  logic        r_illegal;

  logic [31:0] w_op;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_acc;
  logic        w_we;
  logic        w_mapped;
  logic        w_ro;
  logic        w_hit_tohost;
  logic        w_ill;

`ifdef CSR_COUNTERS_EN
  logic [63:0] r_cycle;
  logic [63:0] r_instret;
  logic        w_unused;
  assign w_unused = funct3[2];
`else
  logic        w_unused;
  assign w_unused = ^{funct3[2], inst_retire};
`endif

  assign w_op  = csr_sel ? {27'b0, uimm} : rs1_data;
  assign w_acc = csr_wen & ~stall & (funct3[1:0] != 2'b00);
  assign w_we  = w_acc & ((funct3[1:0] == 2'b01) | (uimm != 5'd0));

  // Address decode: old value, mapped and read-only flags
  always_comb begin
    w_old        = 32'h0;
    w_mapped     = 1'b0;
    w_ro         = 1'b0;
    w_hit_tohost = 1'b0;
    if (csr_addr == TOHOST_ADDR) begin
      w_old        = r_tohost;
      w_mapped     = 1'b1;
      w_hit_tohost = 1'b1;
    end else begin
      case (csr_addr)
`ifdef CSR_COUNTERS_EN
        12'hC00: begin
          w_old    = r_cycle[31:0];
          w_mapped = 1'b1;
          w_ro     = 1'b1;
        end
        12'hC80: begin
          w_old    = r_cycle[63:32];
          w_mapped = 1'b1;
          w_ro     = 1'b1;
        end
        12'hC02: begin
          w_old    = r_instret[31:0];
          w_mapped = 1'b1;
          w_ro     = 1'b1;
        end
        12'hC82: begin
          w_old    = r_instret[63:32];
          w_mapped = 1'b1;
          w_ro     = 1'b1;
        end
`endif
        default: begin
          w_old    = 32'h0;
          w_mapped = 1'b0;
        end
      endcase
    end
  end

  // Read-modify-write value for RW / RS / RC
  always_comb begin
    w_new = w_old;
    unique case (funct3[1:0])
      2'b01:   w_new = w_op;
      2'b10:   w_new = w_old | w_op;
      2'b11:   w_new = w_old & ~w_op;
      default: w_new = w_old;
    endcase
  end

  assign w_ill = w_acc & (~w_mapped | (w_we & w_ro));

  // tohost register: only legal writes commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tohost <= RESET_TOHOST;
    end else if (w_we & w_hit_tohost) begin
      r_tohost <= w_new;
    end
  end

  // Registered old value and illegal pulse toward writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata   <= 32'h0;
      r_illegal <= 1'b0;
    end else if (!stall) begin
      r_rdata   <= w_acc ? w_old : 32'h0;
      r_illegal <= w_ill;
    end else begin
      r_illegal <= 1'b0;
    end
  end

`ifdef CSR_COUNTERS_EN
  // Free-running cycle counter and stall-gated instret counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle   <= 64'h0;
      r_instret <= 64'h0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (inst_retire & ~stall) begin
        r_instret <= r_instret + 64'd1;
      end
    end
  end
`endif

  assign csr_rdata = r_rdata;
  assign tohost    = r_tohost;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed scoreboard bench for csr_unit.
// Counter checks are compiled only with CSR_COUNTERS_EN.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        csr_wen = 1'b0;
  logic        csr_sel = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [11:0] csr_addr = 12'h0;
  logic [4:0]  uimm = 5'h0;
  logic [31:0] rs1_data = 32'h0;
  logic        inst_retire = 1'b0;
  logic [31:0] csr_rdata;
  logic [31:0] tohost;
  logic        illegal;

  localparam logic [2:0] RW  = 3'b001;
  localparam logic [2:0] RS  = 3'b010;
  localparam logic [2:0] RC  = 3'b011;
  localparam logic [2:0] RSI = 3'b110;

  typedef struct {
    logic [31:0] rd;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [63:0] m_cycle = 64'h0;
  logic [63:0] m_instret = 64'h0;

  csr_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .csr_wen     (csr_wen),
    .csr_sel     (csr_sel),
    .funct3      (funct3),
    .csr_addr    (csr_addr),
    .uimm        (uimm),
    .rs1_data    (rs1_data),
    .inst_retire (inst_retire),
    .csr_rdata   (csr_rdata),
    .tohost      (tohost),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Reference counters
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cycle   <= 64'h0;
      m_instret <= 64'h0;
    end else begin
      m_cycle <= m_cycle + 64'd1;
      if (inst_retire && !stall) m_instret <= m_instret + 64'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic sel,
                       input logic [11:0] a, input logic [4:0] u,
                       input logic [31:0] rs, input logic [31:0] erd,
                       input logic eill, input string tag);
    exp_t e;
    @(negedge clk);
    funct3   = f3;
    csr_sel  = sel;
    csr_addr = a;
    uimm     = u;
    rs1_data = rs;
    csr_wen  = 1'b1;
    sb_q.push_back('{erd, eill});
    @(posedge clk);
    #1;
    csr_wen     = 1'b0;
    inst_retire = 1'b0;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".rd"}, csr_rdata, e.rd);
      chk({tag, ".ill"}, {31'b0, illegal}, {31'b0, e.ill});
    end
  endtask

  initial begin
    logic [63:0] mi0;
    logic [63:0] mc0;

    #12;
    chk("rst_tohost", tohost, 32'h0);
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_ill", {31'b0, illegal}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    issue(RW, 1'b0, 12'h51E, 5'd1, 32'h5, 32'h0, 1'b0, "wr5");
    chk("tohost5", tohost, 32'h5);
    issue(RS, 1'b0, 12'h51E, 5'd0, 32'h0, 32'h5, 1'b0, "rd5");
    #1;
    rst = 1'b1;
    #1;
    chk("arst_tohost", tohost, 32'h0);
    chk("arst_rdata", csr_rdata, 32'h0);
    chk("arst_ill", {31'b0, illegal}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
`ifdef CSR_COUNTERS_EN
    issue(RS, 1'b0, 12'hC00, 5'd0, 32'h0, 32'h1, 1'b0, "cyc_first");
`else
    issue(RS, 1'b0, 12'h51E, 5'd0, 32'h0, 32'h0, 1'b0, "th_first");
`endif

    issue(RW, 1'b0, 12'h51E, 5'd1, 32'hDEADBEEF, 32'h0, 1'b0, "rw1");
    chk("th_dead", tohost, 32'hDEADBEEF);
    issue(RW, 1'b0, 12'h51E, 5'd1, 32'h1, 32'hDEADBEEF, 1'b0, "rw2");
    chk("th_1", tohost, 32'h1);

    issue(RW, 1'b0, 12'h51E, 5'd2, 32'hF0, 32'h1, 1'b0, "rwF0");
    chk("th_F0", tohost, 32'hF0);
    issue(RSI, 1'b1, 12'h51E, 5'd3, 32'hFFFF, 32'hF0, 1'b0, "rsi3");
    chk("th_F3", tohost, 32'hF3);
    issue(RC, 1'b0, 12'h51E, 5'd5, 32'h30, 32'hF3, 1'b0, "rc30");
    chk("th_C3", tohost, 32'hC3);
    issue(RS, 1'b0, 12'h51E, 5'd0, 32'hFF, 32'hC3, 1'b0, "rs_x0");
    chk("th_x0", tohost, 32'hC3);
    @(posedge clk);
    #1;
    chk("idle_rd", csr_rdata, 32'h0);

    issue(RS, 1'b0, 12'h51E, 5'd0, 32'h0, 32'hC3, 1'b0, "pre_stall");
    mi0 = m_instret;
    mc0 = m_cycle;
    @(negedge clk);
    stall       = 1'b1;
    csr_wen     = 1'b1;
    funct3      = RW;
    csr_addr    = 12'h51E;
    csr_sel     = 1'b0;
    uimm        = 5'd1;
    rs1_data    = 32'h7;
    inst_retire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_th", tohost, 32'hC3);
      chk("stall_rd", csr_rdata, 32'hC3);
      chk("stall_ill", {31'b0, illegal}, 32'h0);
    end
    stall       = 1'b0;
    csr_wen     = 1'b0;
    inst_retire = 1'b0;
`ifdef CSR_COUNTERS_EN
    issue(RS, 1'b0, 12'hC00, 5'd0, 32'h0, mc0[31:0] + 32'd3, 1'b0, "stall_cyc");
    issue(RS, 1'b0, 12'hC02, 5'd0, 32'h0, mi0[31:0], 1'b0, "stall_ret");

    force dut.r_instret = 64'h0000_0000_FFFF_FFFF;
    m_instret = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.r_instret;
    inst_retire = 1'b1;
    issue(RS, 1'b0, 12'hC02, 5'd0, 32'h0, 32'hFFFFFFFF, 1'b0, "ret_pre");
    issue(RS, 1'b0, 12'hC02, 5'd0, 32'h0, 32'h0, 1'b0, "ret_lo");
    issue(RS, 1'b0, 12'hC82, 5'd0, 32'h0, 32'h1, 1'b0, "ret_hi");

    force dut.r_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cycle = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_cycle;
    issue(RS, 1'b0, 12'hC80, 5'd0, 32'h0, 32'hFFFFFFFF, 1'b0, "cyc_max");
    issue(RS, 1'b0, 12'hC00, 5'd0, 32'h0, 32'h0, 1'b0, "cyc_wlo");
    issue(RS, 1'b0, 12'hC80, 5'd0, 32'h0, 32'h0, 1'b0, "cyc_whi");

    issue(RW, 1'b0, 12'hC00, 5'd1, 32'h5, m_cycle[31:0], 1'b1, "ro_wr");
    issue(RS, 1'b0, 12'hC00, 5'd0, 32'h0, m_cycle[31:0], 1'b0, "ro_after");
`else
    issue(RS, 1'b0, 12'hC00, 5'd0, 32'h0, 32'h0, 1'b1, "nocnt_c00");
`endif

    issue(RS, 1'b0, 12'h123, 5'd0, 32'h0, 32'h0, 1'b1, "unmapped");
    @(posedge clk);
    #1;
    chk("ill_pulse", {31'b0, illegal}, 32'h0);
    chk("th_final", tohost, 32'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
